// File: rtl/clarke_pkg.sv
// clarke_pkg: shared types, widths and scaling constants for the Clarke transform pipeline
package clarke_pkg;
  typedef enum logic {CLARKE_2IN, CLARKE_3IN} clarke_mode_t;
  localparam int CLARKE_MAX_DW = 32;
  localparam int CLARKE_MAX_TW = 16;
  localparam int CLARKE_ACC_W = 2 * CLARKE_MAX_DW + 2;
  typedef struct packed {
    logic signed [CLARKE_ACC_W-1:0] al_acc;
    logic signed [CLARKE_ACC_W-1:0] be_acc;
    clarke_mode_t mode;
    logic [CLARKE_MAX_TW-1:0] tag;
  } clarke_stage_t;
  function automatic longint q_scale(input longint frac_e9, input int w);
    return (frac_e9 * ((longint'(1) << (w - 1)) - 1) + 64'sd500000000) / 64'sd1000000000;
  endfunction
  function automatic longint k_sq3(input int w);
    return q_scale(64'sd577350269, w);
  endfunction
  function automatic longint k_3(input int w);
    return q_scale(64'sd333333333, w);
  endfunction
endpackage

// File: rtl/clarke_pipe_module_round_sat.sv
// clarke_round_sat: round-half-up, arithmetic shift and clamp to OUT_W bits, with clip flag
module clarke_round_sat #(
  parameter int IN_W = 66,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] res,
  output logic                    clip
);
  localparam int RW = IN_W + 1;
  localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] MAX = RW'({(OUT_W-1){1'b1}});
  localparam logic signed [RW-1:0] MIN = ~MAX;
  logic signed [RW-1:0] r;
  logic hi, lo;
  assign r = (RW'(acc) + HALF) >>> SHIFT;
  assign hi = r > MAX;
  assign lo = r < MIN;
  assign clip = hi || lo;
  assign res = hi ? MAX[OUT_W-1:0] : lo ? MIN[OUT_W-1:0] : r[OUT_W-1:0];
endmodule

// File: rtl/clarke_pipe_module.sv
// clarke_pipe_module: 3-stage forward Clarke transform (2- or 3-input per sample) with valid/ready flow control
module clarke_pipe_module
  import clarke_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic                         mode_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic signed [DATA_WIDTH-1:0] c_i,
  input  logic [TAG_WIDTH-1:0]         tag_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic signed [DATA_WIDTH-1:0] al_o,
  output logic signed [DATA_WIDTH-1:0] be_o,
  output logic [TAG_WIDTH-1:0]         tag_o,
  output logic                         sat_o,
  output logic                         sat_sticky_o,
  input  logic                         sat_clear_i
);
  localparam int SW = DATA_WIDTH + 2;
  localparam logic signed [CLARKE_ACC_W-1:0] KSQ3 = CLARKE_ACC_W'(k_sq3(DATA_WIDTH));
  localparam logic signed [CLARKE_ACC_W-1:0] K3 = CLARKE_ACC_W'(k_3(DATA_WIDTH));
  logic v1, v2, ld1, ld2, ld3;
  logic signed [DATA_WIDTH-1:0] a1, b1, c1;
  clarke_mode_t m1;
  logic [TAG_WIDTH-1:0] t1;
  clarke_stage_t s2, s2_d;
  logic signed [SW-1:0] ea, eb, ec, sum_al, sum_be;
  logic signed [CLARKE_ACC_W-1:0] acc_al, acc_be;
  logic signed [DATA_WIDTH-1:0] al_d, be_d;
  logic clip_al, clip_be;
  assign ld3 = !out_valid_o || out_ready_i;
  assign ld2 = !v2 || ld3;
  assign ld1 = !v1 || ld2;
  assign in_ready_o = ld1;
  assign ea = SW'(a1);
  assign eb = SW'(b1);
  assign ec = SW'(c1);
  assign sum_al = (ea <<< 1) - eb - ec;
  assign sum_be = m1 == CLARKE_3IN ? eb - ec : ea + (eb <<< 1);
  // 2-input alpha is pre-scaled by the rounding shift so it passes through the rounder unchanged
  assign acc_al = m1 == CLARKE_3IN ? CLARKE_ACC_W'(sum_al) * K3 : CLARKE_ACC_W'(ea) <<< (DATA_WIDTH - 1);
  assign acc_be = CLARKE_ACC_W'(sum_be) * KSQ3;
  assign s2_d = '{al_acc: acc_al, be_acc: acc_be, mode: m1, tag: CLARKE_MAX_TW'(t1)};
  clarke_round_sat #(.IN_W(CLARKE_ACC_W), .OUT_W(DATA_WIDTH), .SHIFT(DATA_WIDTH - 1)) u_rs_al (
    .acc(s2.al_acc), .res(al_d), .clip(clip_al)
  );
  clarke_round_sat #(.IN_W(CLARKE_ACC_W), .OUT_W(DATA_WIDTH), .SHIFT(DATA_WIDTH - 1)) u_rs_be (
    .acc(s2.be_acc), .res(be_d), .clip(clip_be)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid_o <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      c1 <= '0;
      m1 <= CLARKE_2IN;
      t1 <= '0;
      s2 <= '0;
      al_o <= '0;
      be_o <= '0;
      tag_o <= '0;
      sat_o <= 1'b0;
      sat_sticky_o <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid_i;
      if (ld1 && in_valid_i) begin
        a1 <= a_i;
        b1 <= b_i;
        c1 <= c_i;
        m1 <= clarke_mode_t'(mode_i);
        t1 <= tag_i;
      end
      if (ld2) v2 <= v1;
      if (ld2 && v1) s2 <= s2_d;
      if (ld3) out_valid_o <= v2;
      if (ld3 && v2) begin
        al_o <= al_d;
        be_o <= be_d;
        tag_o <= s2.tag[TAG_WIDTH-1:0];
        sat_o <= clip_be || (s2.mode == CLARKE_3IN && clip_al);
      end
      sat_sticky_o <= (out_valid_o && out_ready_i && sat_o) || (sat_sticky_o && !sat_clear_i);
    end
  end
endmodule
